// File: rtl/reg_wb_ctrl_pkg.sv
// Shared types for the register-file writeback controller: widths, the
// writeback request record and the arbitration grant encoding.
package reg_wb_ctrl_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 1 << REG_AW;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GntNone,
    GntAlu,
    GntLoad
  } gnt_e;

endpackage

// File: rtl/reg_wb_ctrl_if.sv
// Bus bundle for reg_wb_ctrl: ALU result, load issue, load return, hazard
// query and register-file write port.
interface reg_wb_ctrl_if;
  import reg_wb_ctrl_pkg::*;

  logic            alu_valid;
  reg_addr_t       alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;

  logic            ld_iss_valid;
  reg_addr_t       ld_iss_rd;
  logic            ld_iss_ready;

  logic            ld_ret_valid;
  reg_addr_t       ld_ret_rd;
  logic [XLEN-1:0] ld_ret_data;
  logic            ld_ret_ready;

  reg_addr_t       q_rs;
  reg_addr_t       q_rt;
  logic            busy_rs;
  logic            busy_rt;

  logic            wr_en;
  reg_addr_t       wr_addr;
  logic [XLEN-1:0] wr_data;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_iss_valid, ld_iss_rd,
    output ld_ret_valid, ld_ret_rd, ld_ret_data,
    output q_rs, q_rt,
    input  alu_ready, ld_iss_ready, ld_ret_ready, busy_rs, busy_rt,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_iss_valid, ld_iss_rd,
    input  ld_ret_valid, ld_ret_rd, ld_ret_data,
    input  q_rs, q_rt,
    output alu_ready, ld_iss_ready, ld_ret_ready, busy_rs, busy_rt,
    output wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/reg_wb_ctrl_wb_fifo.sv
// Synchronous FIFO of writeback requests for returning loads. Depth must be a
// power of two so the pointers wrap naturally; an occupancy count tells full from empty.
module reg_wb_ctrl_wb_fifo
  import reg_wb_ctrl_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push_i,
  input  wb_req_t wdata_i,
  input  logic    pop_i,
  output wb_req_t rdata_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  wb_req_t         mem_q [Depth];
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; the occupancy count guards every read.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Writeback controller: arbitrates ALU results and buffered load returns onto
// one registered register-file write port and tracks pending loads per register.
module reg_wb_ctrl
  import reg_wb_ctrl_pkg::*;
#(
  parameter int unsigned LQ_DEPTH   = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  reg_wb_ctrl_if.slave   bus_io
);

  localparam int unsigned StarveW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [StarveW-1:0] StarveMaxC = StarveW'(STARVE_MAX);

  wb_req_t             ld_ret_req;
  wb_req_t             ld_head;
  logic                fifo_full, fifo_empty;
  logic                ld_push, ld_pop;
  gnt_e                gnt;
  logic                iss_ready;

  logic [StarveW-1:0]  starve_q, starve_d;
  logic [NUM_REGS-1:0] sb_q, sb_d;
  logic                wr_en_q, wr_en_d;
  reg_addr_t           wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]     wr_data_q, wr_data_d;

  assign ld_ret_req = '{rd: bus_io.ld_ret_rd, data: bus_io.ld_ret_data};
  assign ld_push    = bus_io.ld_ret_valid && !fifo_full;
  assign ld_pop     = (gnt == GntLoad);

  reg_wb_ctrl_wb_fifo #(
    .Depth (LQ_DEPTH)
  ) u_wb_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ld_push),
    .wdata_i (ld_ret_req),
    .pop_i   (ld_pop),
    .rdata_o (ld_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A waiting load that has lost STARVE_MAX times in a row takes the port.
  always_comb begin
    gnt = GntNone;
    if (bus_io.alu_valid && !(!fifo_empty && (starve_q == StarveMaxC))) begin
      gnt = GntAlu;
    end else if (!fifo_empty) begin
      gnt = GntLoad;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || (gnt == GntLoad)) begin
      starve_d = '0;
    end else if ((gnt == GntAlu) && (starve_q != StarveMaxC)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  assign iss_ready = !sb_q[bus_io.ld_iss_rd] || (bus_io.ld_iss_rd == '0);

  // Clear is applied after set so a same-cycle collision leaves the bit clear.
  always_comb begin
    sb_d = sb_q;
    if (bus_io.ld_iss_valid && iss_ready) begin
      sb_d[bus_io.ld_iss_rd] = 1'b1;
    end
    if (ld_pop) begin
      sb_d[ld_head.rd] = 1'b0;
    end
    sb_d[0] = 1'b0;
  end

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (gnt)
      GntAlu: begin
        wr_en_d   = (bus_io.alu_rd != '0);
        wr_addr_d = bus_io.alu_rd;
        wr_data_d = bus_io.alu_data;
      end
      GntLoad: begin
        wr_en_d   = (ld_head.rd != '0);
        wr_addr_d = ld_head.rd;
        wr_data_d = ld_head.data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q  <= '0;
      sb_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      starve_q  <= starve_d;
      sb_q      <= sb_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus_io.alu_ready    = (gnt == GntAlu);
  assign bus_io.ld_iss_ready = iss_ready;
  assign bus_io.ld_ret_ready = !fifo_full;
  assign bus_io.busy_rs      = sb_q[bus_io.q_rs];
  assign bus_io.busy_rt      = sb_q[bus_io.q_rt];
  assign bus_io.wr_en        = wr_en_q;
  assign bus_io.wr_addr      = wr_addr_q;
  assign bus_io.wr_data      = wr_data_q;

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Self-checking bench for reg_wb_ctrl: a vector table of per-cycle stimulus with
// expected handshakes, and a queue of expected writes checked one cycle later.
module tb_reg_wb_ctrl;
  import reg_wb_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_wb_ctrl_if bus ();

  reg_wb_ctrl #(
    .LQ_DEPTH   (4),
    .STARVE_MAX (3)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  typedef struct {
    bit          alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_d;
    bit          iss_v;
    logic [4:0]  iss_rd;
    bit          ret_v;
    logic [4:0]  ret_rd;
    logic [31:0] ret_d;
    logic [4:0]  q_rs;
    logic [4:0]  q_rt;
    bit          e_alu;
    bit          e_iss;
    bit          e_ret;
    bit          e_brs;
    bit          e_brt;
    bit          e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
  } vec_t;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_wr_t;

  vec_t        vecs[$];
  exp_wr_t     exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] pend;
  bit          hold_valid;
  logic [4:0]  last_addr;
  logic [31:0] last_data;

  function automatic vec_t mk(int unsigned av, int unsigned ard, int unsigned ad,
                              int unsigned iv, int unsigned ird,
                              int unsigned rv, int unsigned rrd, int unsigned rd,
                              int unsigned qs, int unsigned qt,
                              int unsigned ea, int unsigned ei, int unsigned er,
                              int unsigned bs, int unsigned bt,
                              int unsigned we, int unsigned wa, int unsigned wd);
    vec_t r;
    r.alu_v = av[0];  r.alu_rd = ard[4:0]; r.alu_d = ad;
    r.iss_v = iv[0];  r.iss_rd = ird[4:0];
    r.ret_v = rv[0];  r.ret_rd = rrd[4:0]; r.ret_d = rd;
    r.q_rs  = qs[4:0]; r.q_rt  = qt[4:0];
    r.e_alu = ea[0];  r.e_iss = ei[0];   r.e_ret = er[0];
    r.e_brs = bs[0];  r.e_brt = bt[0];
    r.e_we  = we[0];  r.e_wa  = wa[4:0];  r.e_wd  = wd;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic step(input vec_t v, input string tag);
    exp_wr_t e;
    bus.alu_valid    = v.alu_v;
    bus.alu_rd       = v.alu_rd;
    bus.alu_data     = v.alu_d;
    bus.ld_iss_valid = v.iss_v;
    bus.ld_iss_rd    = v.iss_rd;
    bus.ld_ret_valid = v.ret_v;
    bus.ld_ret_rd    = v.ret_rd;
    bus.ld_ret_data  = v.ret_d;
    bus.q_rs         = v.q_rs;
    bus.q_rt         = v.q_rt;
    #1;
    check($sformatf("%s alu_ready", tag), 32'(bus.alu_ready), 32'(v.e_alu));
    check($sformatf("%s ld_iss_ready", tag), 32'(bus.ld_iss_ready), 32'(v.e_iss));
    check($sformatf("%s ld_ret_ready", tag), 32'(bus.ld_ret_ready), 32'(v.e_ret));
    check($sformatf("%s busy_rs", tag), 32'(bus.busy_rs), 32'(v.e_brs));
    check($sformatf("%s busy_rt", tag), 32'(bus.busy_rt), 32'(v.e_brt));
    if (v.iss_v && v.e_iss && v.iss_rd != 5'd0) pend[v.iss_rd] = 1'b1;
    if (v.ret_v && v.e_ret) begin
      assert (pend[v.ret_rd]) else $error("protocol error: %s returns idle rd %0d", tag, v.ret_rd);
      pend[v.ret_rd] = 1'b0;
    end
    exp_q.push_back('{en: v.e_we, addr: v.e_wa, data: v.e_wd});
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check($sformatf("%s wr_en", tag), 32'(bus.wr_en), 32'(e.en));
    if (e.en) begin
      check($sformatf("%s wr_addr", tag), 32'(bus.wr_addr), 32'(e.addr));
      check($sformatf("%s wr_data", tag), bus.wr_data, e.data);
      last_addr  = e.addr;
      last_data  = e.data;
      hold_valid = 1'b1;
    end else if (v.e_alu && v.alu_rd == 5'd0) begin
      hold_valid = 1'b0;
    end else if (hold_valid) begin
      check($sformatf("%s wr_addr hold", tag), 32'(bus.wr_addr), 32'(last_addr));
      check($sformatf("%s wr_data hold", tag), bus.wr_data, last_data);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check($sformatf("%s wr_en", tag), 32'(bus.wr_en), 32'd0);
    check($sformatf("%s wr_addr", tag), 32'(bus.wr_addr), 32'd0);
    check($sformatf("%s wr_data", tag), bus.wr_data, 32'd0);
    pend       = '0;
    hold_valid = 1'b1;
    last_addr  = '0;
    last_data  = '0;
  endtask

  initial begin
    bus.alu_valid    = 1'b0;
    bus.alu_rd       = '0;
    bus.alu_data     = '0;
    bus.ld_iss_valid = 1'b0;
    bus.ld_iss_rd    = '0;
    bus.ld_ret_valid = 1'b0;
    bus.ld_ret_rd    = '0;
    bus.ld_ret_data  = '0;
    bus.q_rs         = '0;
    bus.q_rt         = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    check("reset ld_ret_ready", 32'(bus.ld_ret_ready), 32'd1);
    rst = 1'b0;

    // av ard ad | iv ird | rv rrd rd | qs qt | e_alu e_iss e_ret b_rs b_rt | we wa wd
    // ALU write, rd=0 suppression, load scoreboard round trip
    vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 5, 32'hDEADBEEF));
    vecs.push_back(mk(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8, 0, 0, 0, 8, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8, 0, 0, 0, 8, 8, 0, 0, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8, 32'h55, 8, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 1, 1, 1, 0, 1, 8, 32'h55));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    // Starvation: one load waiting while the ALU stays busy
    vecs.push_back(mk(0, 0, 0, 1, 3, 0, 0, 0, 3, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 10, 32'hA0, 0, 0, 1, 3, 32'h333, 3, 0, 1, 1, 1, 1, 0, 1, 10, 32'hA0));
    vecs.push_back(mk(1, 11, 32'hA1, 0, 0, 0, 0, 0, 3, 0, 1, 1, 1, 1, 0, 1, 11, 32'hA1));
    vecs.push_back(mk(1, 12, 32'hA2, 0, 0, 0, 0, 0, 3, 0, 1, 1, 1, 1, 0, 1, 12, 32'hA2));
    vecs.push_back(mk(1, 13, 32'hA3, 0, 0, 0, 0, 0, 3, 0, 1, 1, 1, 1, 0, 1, 13, 32'hA3));
    vecs.push_back(mk(1, 14, 32'hA4, 0, 0, 0, 0, 0, 3, 0, 0, 1, 1, 1, 0, 1, 3, 32'h333));
    vecs.push_back(mk(1, 14, 32'hA4, 0, 0, 0, 0, 0, 3, 0, 1, 1, 1, 0, 0, 1, 14, 32'hA4));
    // FIFO full: four returns under ALU pressure, fifth refused, in-order drain
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 2, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 3, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 4, 0, 0, 0, 1, 4, 0, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 20, 32'hB0, 0, 0, 1, 1, 32'hD1, 1, 4, 1, 1, 1, 1, 1, 1, 20, 32'hB0));
    vecs.push_back(mk(1, 21, 32'hB1, 0, 0, 1, 2, 32'hD2, 1, 4, 1, 1, 1, 1, 1, 1, 21, 32'hB1));
    vecs.push_back(mk(1, 22, 32'hB2, 0, 0, 1, 3, 32'hD3, 1, 4, 1, 1, 1, 1, 1, 1, 22, 32'hB2));
    vecs.push_back(mk(1, 23, 32'hB3, 0, 0, 1, 4, 32'hD4, 1, 4, 1, 1, 1, 1, 1, 1, 23, 32'hB3));
    vecs.push_back(mk(1, 24, 32'hB4, 0, 0, 1, 5, 32'hD5, 1, 4, 0, 1, 0, 1, 1, 1, 1, 32'hD1));
    vecs.push_back(mk(1, 24, 32'hB4, 0, 0, 0, 0, 0, 1, 2, 1, 1, 1, 0, 1, 1, 24, 32'hB4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 4, 0, 1, 1, 1, 1, 1, 2, 32'hD2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 4, 0, 1, 1, 1, 1, 1, 3, 32'hD3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 2, 0, 1, 1, 1, 0, 1, 4, 32'hD4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 1, 1, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("v%0d", i));
    end

    // Reset mid-operation: two loads buffered and two scoreboard bits set
    step(mk(0, 0, 0, 1, 6, 0, 0, 0, 6, 7, 0, 1, 1, 0, 0, 0, 0, 0), "r0");
    step(mk(0, 0, 0, 1, 7, 0, 0, 0, 6, 7, 0, 1, 1, 1, 0, 0, 0, 0), "r1");
    step(mk(1, 25, 32'hC0, 0, 0, 1, 6, 32'hE6, 6, 7, 1, 1, 1, 1, 1, 1, 25, 32'hC0), "r2");
    step(mk(1, 26, 32'hC1, 0, 0, 1, 7, 32'hE7, 6, 7, 1, 1, 1, 1, 1, 1, 26, 32'hC1), "r3");
    rst              = 1'b1;
    bus.alu_valid    = 1'b1;
    bus.alu_rd       = 5'd27;
    bus.alu_data     = 32'hC2;
    bus.ld_iss_valid = 1'b1;
    bus.ld_iss_rd    = 5'd9;
    bus.ld_ret_valid = 1'b1;
    bus.ld_ret_rd    = 5'd9;
    bus.ld_ret_data  = 32'hE9;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("midrst");
    rst = 1'b0;
    step(mk(0, 0, 0, 0, 6, 0, 0, 0, 6, 7, 0, 1, 1, 0, 0, 0, 0, 0), "p0");
    step(mk(0, 0, 0, 0, 7, 0, 0, 0, 9, 7, 0, 1, 1, 0, 0, 0, 0, 0), "p1");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 6, 9, 0, 1, 1, 0, 0, 0, 0, 0), "p2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
